// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions.
//   ARM_ADDR_W / ARM_DATA_W : default byte-address and instruction widths
//   INSTR_NOP               : pipeline bubble (all-zero word, not the AL-cond NOP)
//   is_pow2()               : elaboration-time helper for depth checks
package arm_pkg;

    localparam int unsigned ARM_ADDR_W = 32;
    localparam int unsigned ARM_DATA_W = 32;

    localparam logic [31:0] INSTR_NOP = 32'b0;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/instr_mem_sync_if.sv
// Fetch + program-load bus of the instruction memory.
//   master : pipeline / loader side (drives fetch and prog requests)
//   slave  : memory side (returns instr, instr_valid, fetch_fault, prog_err)
interface instr_mem_sync_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_stall;
    logic              fetch_flush;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              fetch_fault;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              prog_err;

    modport master (
        output fetch_addr, fetch_stall, fetch_flush, prog_we, prog_addr, prog_data,
        input  instr, instr_valid, fetch_fault, prog_err
    );

    modport slave (
        input  fetch_addr, fetch_stall, fetch_flush, prog_we, prog_addr, prog_data,
        output instr, instr_valid, fetch_fault, prog_err
    );
endinterface

// File: rtl/instr_mem_sync_ram.sv
// ram_1r1w_sync: DEPTH x DATA_W RAM, one write port, one registered read port.
//   clk   : rising-edge clock
//   we    : write enable, waddr/wdata : write index/data
//   re    : read enable; rdata holds its value while re=0
//   raddr : read index, rdata : registered read data
// A same-edge write and read to the same index returns the new data (write-first).
// Contents start at zero; INIT_FILE is kept for parameter compatibility only.
module ram_1r1w_sync #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned DATA_W    = 32,
  parameter              INIT_FILE = "",
  localparam int unsigned IDX_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end
endmodule

// File: rtl/instr_mem_sync.sv
// instr_mem_sync: registered-read instruction memory for the IF stage.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : instr_mem_sync_if slave
//     fetch_addr/fetch_stall/fetch_flush -> instr, instr_valid, fetch_fault (1-cycle latency)
//     prog_we/prog_addr/prog_data        -> memory write, prog_err
// Fetch register priority after reset: flush > stall > fetch.
// Out-of-range fetches return INSTR_NOP with fault; misaligned in-range fetches
// return the word at the truncated index with fault. Upper address bits are
// checked, never masked, so addresses do not wrap.
module instr_mem_sync
    import arm_pkg::*;
#(
    parameter int unsigned ADDR_W    = ARM_ADDR_W,
    parameter int unsigned DATA_W    = ARM_DATA_W,
    parameter int unsigned DEPTH     = 256,
    parameter              INIT_FILE = ""
) (
    input logic            clk,
    input logic            rst,
    instr_mem_sync_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("instr_mem_sync: DEPTH must be a power of 2 and >= 2");
    end

    logic [IDX_W-1:0]  f_idx, p_idx;
    logic              f_inr, f_mis, p_ok;
    logic              ram_we, ram_re;
    logic [DATA_W-1:0] ram_rdata;

    logic valid_q, fault_q, oor_q, perr_q;

    always_comb begin
        f_idx = bus.fetch_addr[IDX_W+1:2];
        p_idx = bus.prog_addr[IDX_W+1:2];
        f_inr = (bus.fetch_addr >> (IDX_W + 2)) == '0;
        f_mis = bus.fetch_addr[1:0] != 2'b00;
        p_ok  = ((bus.prog_addr >> (IDX_W + 2)) == '0) && (bus.prog_addr[1:0] == 2'b00);
    end

    // The RAM read register doubles as the instr holding register: it only
    // advances on a real fetch, so stall needs no extra data register, and
    // reset/flush/out-of-range are applied by masking on the way out.
    always_comb begin
        ram_we = bus.prog_we && p_ok && !rst;
        ram_re = !rst && !bus.fetch_flush && !bus.fetch_stall;
    end

    ram_1r1w_sync #(
        .DEPTH     (DEPTH),
        .DATA_W    (DATA_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (p_idx),
        .wdata (bus.prog_data),
        .re    (ram_re),
        .raddr (f_idx),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            oor_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            if (bus.fetch_flush) begin
                valid_q <= 1'b0;
                fault_q <= 1'b0;
                oor_q   <= 1'b0;
            end else if (!bus.fetch_stall) begin
                valid_q <= 1'b1;
                fault_q <= !f_inr || f_mis;
                oor_q   <= !f_inr;
            end
            if (bus.prog_we) begin
                perr_q <= !p_ok;
            end
        end
    end

    always_comb begin
        bus.instr       = (valid_q && !oor_q) ? ram_rdata : DATA_W'(INSTR_NOP);
        bus.instr_valid = valid_q;
        bus.fetch_fault = fault_q;
        bus.prog_err    = perr_q;
    end
endmodule

// File: tb/tb_instr_mem_sync.sv
module tb_instr_mem_sync;
    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] LIMIT = DEPTH * 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_mem_sync_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    instr_mem_sync #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .DEPTH     (DEPTH),
        .INIT_FILE ("")
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // behavioural reference: byte-addressed arithmetic, write applied before read
    logic [31:0] mm [DEPTH];
    logic [31:0] m_instr;
    logic        m_valid, m_fault, m_perr;

    task automatic model_edge();
        if (rst) begin
            m_instr = 0; m_valid = 0; m_fault = 0; m_perr = 0;
        end else begin
            if (bus.prog_we) begin
                if (bus.prog_addr < LIMIT && bus.prog_addr % 4 == 0) begin
                    mm[bus.prog_addr / 4] = bus.prog_data;
                    m_perr = 0;
                end else begin
                    m_perr = 1;
                end
            end
            if (bus.fetch_flush) begin
                m_instr = 0; m_valid = 0; m_fault = 0;
            end else if (!bus.fetch_stall) begin
                m_valid = 1;
                if (bus.fetch_addr < LIMIT) begin
                    m_instr = mm[bus.fetch_addr / 4];
                    m_fault = (bus.fetch_addr % 4) != 0;
                end else begin
                    m_instr = 0;
                    m_fault = 1;
                end
            end
        end
    endtask

    task automatic drive(input logic r, input logic st, input logic fl, input logic [31:0] fa,
                         input logic we, input logic [31:0] pa, input logic [31:0] pd);
        rst = r;
        bus.fetch_stall = st; bus.fetch_flush = fl; bus.fetch_addr = fa;
        bus.prog_we = we; bus.prog_addr = pa; bus.prog_data = pd;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] ei, input logic ev,
                           input logic ef, input logic ep);
        chk({tag, ".instr"}, bus.instr, ei);
        chk({tag, ".valid"}, {31'b0, bus.instr_valid}, {31'b0, ev});
        chk({tag, ".fault"}, {31'b0, bus.fetch_fault}, {31'b0, ef});
        chk({tag, ".perr"},  {31'b0, bus.prog_err},    {31'b0, ep});
    endtask

    typedef struct {
        logic        r, st, fl, we;
        logic [31:0] fa, pa, pd;
        logic [31:0] ei;
        logic        ev, ef, ep;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic st, input logic fl, input logic [31:0] fa,
                                input logic we, input logic [31:0] pa, input logic [31:0] pd,
                                input logic [31:0] ei, input logic ev, input logic ef, input logic ep);
        vec_t v;
        v.r = r; v.st = st; v.fl = fl; v.fa = fa; v.we = we; v.pa = pa; v.pd = pd;
        v.ei = ei; v.ev = ev; v.ef = ef; v.ep = ep;
        return v;
    endfunction

    localparam logic [31:0] W0 = 32'hE3A00014;
    localparam logic [31:0] W1 = 32'hE3A01005;
    localparam logic [31:0] W2 = 32'hE0802001;
    localparam logic [31:0] W3 = 32'h12345678;
    localparam logic [31:0] W4 = 32'hE2811001;

    vec_t tbl[$];

    initial begin
        for (int i = 0; i < DEPTH; i++) mm[i] = 0;
        m_instr = 0; m_valid = 0; m_fault = 0; m_perr = 0;
        drive(1, 0, 0, 0, 0, 0, 0);

        //          r st fl fa        we pa        pd           ei  v  f  pe
        tbl.push_back(mk(1, 0, 0, 32'h0,   0, 32'h0,   0,    0,  0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,   0, 32'h0,   0,    0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32'h0,   1, 32'h0,   W0,   0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   0,    W0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,   1, 32'h4,   W1,   W0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,   1, 32'h8,   W2,   W0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h4,   0, 32'h0,   0,    W1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 32'h8,   0, 32'h0,   0,    W1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 32'h8,   0, 32'h0,   0,    W1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 32'h8,   0, 32'h0,   0,    W1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h8,   0, 32'h0,   0,    W2, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 32'h8,   0, 32'h0,   0,    0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   0,    W0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h400, 0, 32'h0,   0,    0,  1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h6,   0, 32'h0,   0,    W1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,   1, 32'h402, 32'hDEADBEEF, W0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 32'h0,   1, 32'hC,   W3,   W0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'hC,   0, 32'h0,   0,    W3, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h10,  1, 32'h10,  W4,   W4, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h4,   1, 32'h5,   32'hFFFFFFFF, W1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 32'h4,   0, 32'h0,   0,    W1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 32'h80000000, 0, 32'h0, 0, 0,  1, 1, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].st, tbl[i].fl, tbl[i].fa, tbl[i].we, tbl[i].pa, tbl[i].pd);
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].ei, tbl[i].ev, tbl[i].ef, tbl[i].ep);
        end

        // reset during a stall with a valid word, plus a write that must be ignored
        drive(0, 0, 0, 32'h4, 0, 0, 0);
        step();
        chk_all("rst.pre", W1, 1, 0, 1);
        drive(1, 1, 0, 32'h4, 1, 32'h0, 32'hBADBAD00);
        step();
        chk_all("rst.stall", 0, 0, 0, 0);
        drive(0, 1, 0, 32'h0, 0, 0, 0);
        step();
        chk_all("rst.post_stall", 0, 0, 0, 0);
        drive(0, 0, 0, 32'h0, 0, 0, 0);
        step();
        chk_all("rst.rd0", W0, 1, 0, 0);
        drive(0, 0, 0, 32'h10, 0, 0, 0);
        step();
        chk_all("rst.rd10", W4, 1, 0, 0);

        // randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] fa, pa;
            case ($urandom_range(0, 5))
                0, 1, 2: fa = $urandom_range(0, 15) * 4;
                3:       fa = $urandom_range(0, 63);
                4:       fa = LIMIT + $urandom_range(0, 15) * 4;
                default: fa = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0, 1, 2: pa = $urandom_range(0, 15) * 4;
                3:       pa = $urandom_range(0, 63);
                4:       pa = LIMIT + $urandom_range(0, 15) * 4;
                default: pa = $urandom;
            endcase
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, fa, $urandom_range(0, 1) == 1, pa, $urandom);
            step();
            chk_all("rand", m_instr, m_valid, m_fault, m_perr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
